sm3_req_arb: RTL and testbench
==============================

# sm3_req_arb

Two-requester arbiter and sequencer in front of a single SM3 core. Grants the core's message input bus to one requester for an entire message, from first word through the `lst` word. Holds the grant until that message's compression result returns, then routes the 256-bit digest back to the owning requester. Sits between the host-side message sources and the pad/expand/compress chain.

## Interface
Parameters:
- `INPT_DW`, 32, message word width; must be 32 or 64.
- `INPT_BYTE_DW`, `INPT_DW/8`, byte-valid width.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rq0_msg_d`, `rq1_msg_d`  in  INPT_DW  requester message word.
- `rq0_msg_vld_byte`, `rq1_msg_vld_byte`  in  INPT_BYTE_DW  byte valids; meaningful on `lst` only.
- `rq0_msg_vld`, `rq1_msg_vld`  in  1  word valid.
- `rq0_msg_lst`, `rq1_msg_lst`  in  1  last word of message.
- `rq0_msg_rdy`, `rq1_msg_rdy`  out  1  word accepted when `vld & rdy`.
- `msg_inpt_d`  out  INPT_DW  to core.
- `msg_inpt_vld_byte`  out  INPT_BYTE_DW  to core.
- `msg_inpt_vld`  out  1  to core.
- `msg_inpt_lst`  out  1  to core.
- `msg_inpt_rdy`  in  1  from core.
- `cmprss_otpt_res`  in  256  digest from core.
- `cmprss_otpt_vld`  in  1  digest valid pulse.
- `res_d`  out  256  registered digest.
- `res_vld0`, `res_vld1`  out  1  one-cycle digest pulse to the owning requester.
- `gnt`  out  2  one-hot current owner; 0 when idle.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky: `cmprss_otpt_vld` seen outside WAIT_RES.

## Operation
- FSM states: IDLE, XFER, WAIT_RES.
- IDLE:
  - Sample `rq0_msg_vld` and `rq1_msg_vld`. If any is high, register the winner into `gnt` and go to XFER.
  - Round-robin: if both are high, grant the requester not granted last. `last_gnt` resets to 1, so ch0 wins the first tie.
  - In IDLE both `rqN_msg_rdy` = 0 and `msg_inpt_vld` = 0.
- XFER:
  - Combinational pass-through of d, vld_byte, vld and lst from the granted requester to the core.
  - `msg_inpt_rdy` is returned to the granted requester only; the other requester sees `rdy` = 0.
  - On the handshake `msg_inpt_vld & msg_inpt_rdy & msg_inpt_lst`, go to WAIT_RES.
- WAIT_RES:
  - All `rdy` = 0 and `msg_inpt_vld` = 0.
  - On `cmprss_otpt_vld`: register `cmprss_otpt_res` into `res_d`, pulse `res_vldN` for the granted N on the next cycle, set `last_gnt` = N, clear `gnt`, and go to IDLE.
- `err` is set by `cmprss_otpt_vld` in IDLE or XFER. That pulse is otherwise ignored. `err` clears only on reset.
- `res_d` holds its value until the next capture.

## Timing
- Reset values: `gnt` = 0, `busy` = 0, `err` = 0, `res_d` = 0, `res_vld0/1` = 0, `rqN_msg_rdy` = 0, `msg_inpt_vld` = 0, `msg_inpt_lst` = 0.
  - `msg_inpt_d` and `msg_inpt_vld_byte` are driven 0 when no grant is held.
  - Internal state: FSM = IDLE, `last_gnt` = 1.
- Grant latency: requester `vld` high in cycle T (IDLE) → `gnt` valid and pass-through active in T+1. The first word can be accepted in T+1.
- Pass-through adds 0 cycles of latency. The word-rate throughput equals the core's.
- Result latency: `cmprss_otpt_vld` in cycle T → `res_vldN` = 1 and `res_d` valid in T+1. The FSM is in IDLE in T+1 and can issue a new grant, effective T+2.
- Simultaneous events:
  - `vld` arriving in the same cycle as the WAIT_RES→IDLE transition is not sampled until IDLE.
  - A single-word message (`lst` on the first word) goes XFER→WAIT_RES after one handshake.
- Requesters must hold `vld` and data stable until `rdy` (AXI-stream rule). The arbiter never deasserts `rdy` mid-word except by the FSM leaving XFER.
- Asynchronous reset mid-message: all outputs return to reset values immediately. A partial message is abandoned; the core must be reset together with the arbiter.

## Test plan
- Single requester, 3-word message on ch0 (`INPT_DW` = 32, `lst` on word 3, `vld_byte` = 4'b1100), core `rdy` always 1.
  - Required: `gnt` = 01 one cycle after `vld`; 3 handshakes; WAIT_RES.
  - Then `cmprss_otpt_vld` with res = 256'h66c7f0f4… → `res_vld0` pulse next cycle, `res_d` equal, `res_vld1` stays 0.
- Both requesters assert `vld` in the same IDLE cycle, repeated 4 times.
  - Required: grants alternate 01, 10, 01, 10. Each digest is routed to the matching `res_vldN`.
- Core back-pressure: `msg_inpt_rdy` toggles every cycle during a 16-word ch1 message.
  - Required: exactly 16 accepted words, in order, bit-exact. `rq0_msg_rdy` is 0 throughout.
- ch1 sends `lst` while ch0 `vld` is pending; the digest returns 20 cycles later.
  - Required: ch0 `rdy` stays 0 until after `res_vld1`. ch0 is granted 2 cycles after `cmprss_otpt_vld`.
- `cmprss_otpt_vld` injected while in XFER.
  - Required: `err` = 1 and sticky, no `res_vld` pulse, and the transfer continues unaffected.
- `rst_n` dropped after word 2 of a 5-word message.
  - Required: all outputs at reset values in the same cycle. After release, a tie grants ch0 first.

Source files
------------

// File: rtl/sm3_req_arb.sv
// Two-requester round-robin arbiter in front of a single SM3 core.
// Holds the grant for a whole message plus its compression, then routes the digest back.
module sm3_req_arb #(
    parameter int INPT_DW      = 32,
    parameter int INPT_BYTE_DW = INPT_DW / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPT_DW-1:0]      rq0_msg_d,
    input  logic [INPT_BYTE_DW-1:0] rq0_msg_vld_byte,
    input  logic                    rq0_msg_vld,
    input  logic                    rq0_msg_lst,
    output logic                    rq0_msg_rdy,
    input  logic [INPT_DW-1:0]      rq1_msg_d,
    input  logic [INPT_BYTE_DW-1:0] rq1_msg_vld_byte,
    input  logic                    rq1_msg_vld,
    input  logic                    rq1_msg_lst,
    output logic                    rq1_msg_rdy,
    output logic [INPT_DW-1:0]      msg_inpt_d,
    output logic [INPT_BYTE_DW-1:0] msg_inpt_vld_byte,
    output logic                    msg_inpt_vld,
    output logic                    msg_inpt_lst,
    input  logic                    msg_inpt_rdy,
    input  logic [255:0]            cmprss_otpt_res,
    input  logic                    cmprss_otpt_vld,
    output logic [255:0]            res_d,
    output logic                    res_vld0,
    output logic                    res_vld1,
    output logic [1:0]              gnt,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT_RES
    } state_t;

    state_t state;
    logic   last_gnt;  // index of the requester served most recently
    logic   xfer;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            last_gnt <= 1'b1;
            res_d    <= '0;
            res_vld0 <= 1'b0;
            res_vld1 <= 1'b0;
            err      <= 1'b0;
        end else begin
            res_vld0 <= 1'b0;
            res_vld1 <= 1'b0;
            if (cmprss_otpt_vld && state != WAIT_RES) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rq0_msg_vld && rq1_msg_vld) begin
                        gnt   <= last_gnt ? 2'b01 : 2'b10;
                        state <= XFER;
                    end else if (rq0_msg_vld) begin
                        gnt   <= 2'b01;
                        state <= XFER;
                    end else if (rq1_msg_vld) begin
                        gnt   <= 2'b10;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (msg_inpt_vld && msg_inpt_rdy && msg_inpt_lst) begin
                        state <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (cmprss_otpt_vld) begin
                        res_d    <= cmprss_otpt_res;
                        res_vld0 <= gnt[0];
                        res_vld1 <= gnt[1];
                        last_gnt <= gnt[1];
                        gnt      <= 2'b00;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign xfer = (state == XFER);
    assign busy = (state != IDLE);

    // Zero-latency pass-through; data is zeroed whenever no grant is held.
    // NOTE: every output of this always_comb gets a default first so no latch is inferred.
    always_comb begin
        msg_inpt_d        = '0;
        msg_inpt_vld_byte = '0;
        msg_inpt_vld      = 1'b0;
        msg_inpt_lst      = 1'b0;
        rq0_msg_rdy       = 1'b0;
        rq1_msg_rdy       = 1'b0;
        if (gnt[0]) begin
            msg_inpt_d        = rq0_msg_d;
            msg_inpt_vld_byte = rq0_msg_vld_byte;
            msg_inpt_vld      = xfer & rq0_msg_vld;
            msg_inpt_lst      = xfer & rq0_msg_lst;
            rq0_msg_rdy       = xfer & msg_inpt_rdy;
        end else if (gnt[1]) begin
            msg_inpt_d        = rq1_msg_d;
            msg_inpt_vld_byte = rq1_msg_vld_byte;
            msg_inpt_vld      = xfer & rq1_msg_vld;
            msg_inpt_lst      = xfer & rq1_msg_lst;
            rq1_msg_rdy       = xfer & msg_inpt_rdy;
        end
    end

endmodule

// File: tb/tb_sm3_req_arb.sv
// Directed self-checking bench for sm3_req_arb with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns later.
module tb_sm3_req_arb;

    localparam int DW  = 32;
    localparam int BDW = DW / 8;
    localparam logic [255:0] ABC_DIGEST =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  rq0_msg_d = '0, rq1_msg_d = '0;
    logic [BDW-1:0] rq0_msg_vld_byte = '0, rq1_msg_vld_byte = '0;
    logic           rq0_msg_vld = 1'b0, rq1_msg_vld = 1'b0;
    logic           rq0_msg_lst = 1'b0, rq1_msg_lst = 1'b0;
    logic           rq0_msg_rdy, rq1_msg_rdy;
    logic [DW-1:0]  msg_inpt_d;
    logic [BDW-1:0] msg_inpt_vld_byte;
    logic           msg_inpt_vld, msg_inpt_lst;
    logic           msg_inpt_rdy = 1'b1;
    logic [255:0]   cmprss_otpt_res = '0;
    logic           cmprss_otpt_vld = 1'b0;
    logic [255:0]   res_d;
    logic           res_vld0, res_vld1;
    logic [1:0]     gnt;
    logic           busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    sm3_req_arb #(.INPT_DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_msg_d(rq0_msg_d), .rq0_msg_vld_byte(rq0_msg_vld_byte),
        .rq0_msg_vld(rq0_msg_vld), .rq0_msg_lst(rq0_msg_lst), .rq0_msg_rdy(rq0_msg_rdy),
        .rq1_msg_d(rq1_msg_d), .rq1_msg_vld_byte(rq1_msg_vld_byte),
        .rq1_msg_vld(rq1_msg_vld), .rq1_msg_lst(rq1_msg_lst), .rq1_msg_rdy(rq1_msg_rdy),
        .msg_inpt_d(msg_inpt_d), .msg_inpt_vld_byte(msg_inpt_vld_byte),
        .msg_inpt_vld(msg_inpt_vld), .msg_inpt_lst(msg_inpt_lst), .msg_inpt_rdy(msg_inpt_rdy),
        .cmprss_otpt_res(cmprss_otpt_res), .cmprss_otpt_vld(cmprss_otpt_vld),
        .res_d(res_d), .res_vld0(res_vld0), .res_vld1(res_vld1),
        .gnt(gnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int ch, input logic vld, input logic [DW-1:0] d,
                       input logic lst, input logic [BDW-1:0] vb);
        if (ch == 0) begin
            rq0_msg_vld = vld; rq0_msg_d = d; rq0_msg_lst = lst; rq0_msg_vld_byte = vb;
        end else begin
            rq1_msg_vld = vld; rq1_msg_d = d; rq1_msg_lst = lst; rq1_msg_vld_byte = vb;
        end
    endtask

    function automatic logic [DW-1:0] word(input int ch, input int i);
        return {4'hA, 4'(ch), 24'h0} + DW'(i) * 32'h0001_0101;
    endfunction

    // Send words [first, stop) of a total-word message on ch; core rdy toggles if asked.
    task automatic send_msg(input int ch, input int first, input int stop, input int total,
                            input logic [BDW-1:0] vb, input bit toggle);
        int i = first;
        int cyc = 0;
        bit hs;
        while (i < stop && cyc < 200) begin
            drv(ch, 1'b1, word(ch, i), i == total - 1, (i == total - 1) ? vb : '0);
            msg_inpt_rdy = toggle ? cyc[0] : 1'b1;
            #1;
            check("other_rdy_low", (ch == 0) ? rq1_msg_rdy : rq0_msg_rdy, 0);
            if (msg_inpt_vld) begin
                check("word_data", msg_inpt_d, word(ch, i));
                check("word_lst", msg_inpt_lst, i == total - 1);
                if (i == total - 1) check("word_vld_byte", msg_inpt_vld_byte, vb);
            end
            hs = msg_inpt_vld & msg_inpt_rdy;
            step();
            if (hs) i++;
            cyc++;
        end
        check("words_accepted", i, stop);
        drv(ch, 1'b0, '0, 1'b0, '0);
        msg_inpt_rdy = 1'b1;
    endtask

    // Return a digest and check it lands on the expected requester for exactly one cycle.
    task automatic return_res(input logic [255:0] val, input int exp_ch);
        cmprss_otpt_res = val;
        cmprss_otpt_vld = 1'b1;
        #1;
        step();
        cmprss_otpt_vld = 1'b0;
        #1;
        check("res_vld0_pulse", res_vld0, exp_ch == 0);
        check("res_vld1_pulse", res_vld1, exp_ch == 1);
        check("res_d", res_d, val);
        check("gnt_clear", gnt, 0);
        check("busy_idle", busy, 0);
        step();
        check("res_vld_drop", {res_vld1, res_vld0}, 0);
        check("res_d_hold", res_d, val);
    endtask

    initial begin
        logic [1:0] exp_gnt;

        // Reset state
        #12;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_res_d", res_d, 0);
        check("rst_res_vld", {res_vld1, res_vld0}, 0);
        check("rst_rdy", {rq1_msg_rdy, rq0_msg_rdy}, 0);
        check("rst_inpt", {msg_inpt_vld, msg_inpt_lst, msg_inpt_d, msg_inpt_vld_byte}, 0);
        rst_n = 1'b1;
        step();

        // 3-word message on ch0, grant one cycle after vld
        drv(0, 1'b1, word(0, 0), 1'b0, '0);
        #1;
        check("t1_idle_gnt", gnt, 0);
        check("t1_idle_rdy", rq0_msg_rdy, 0);
        check("t1_idle_vld", msg_inpt_vld, 0);
        step();
        check("t1_gnt", gnt, 2'b01);
        check("t1_rdy", rq0_msg_rdy, 1);
        send_msg(0, 0, 3, 3, 4'b1100, 1'b0);
        check("t1_wait_busy", busy, 1);
        check("t1_wait_vld", msg_inpt_vld, 0);
        check("t1_wait_gnt", gnt, 2'b01);
        return_res(ABC_DIGEST, 0);

        // 16-word ch1 message with core back-pressure toggling every cycle
        drv(1, 1'b1, word(1, 0), 1'b0, '0);
        step();
        check("t3_gnt", gnt, 2'b10);
        send_msg(1, 0, 16, 16, 4'b1111, 1'b1);
        check("t3_wait_busy", busy, 1);
        return_res(256'h1234, 1);

        // Four ties: grants alternate starting with ch0
        for (int k = 0; k < 4; k++) begin
            exp_gnt = k[0] ? 2'b10 : 2'b01;
            drv(0, 1'b1, word(0, k), 1'b1, 4'b0001);
            drv(1, 1'b1, word(1, k), 1'b1, 4'b0011);
            step();
            check("tie_gnt", gnt, exp_gnt);
            check("tie_data", msg_inpt_d, k[0] ? word(1, k) : word(0, k));
            step();
            drv(0, 1'b0, '0, 1'b0, '0);
            drv(1, 1'b0, '0, 1'b0, '0);
            check("tie_wait", {busy, msg_inpt_vld}, 2'b10);
            return_res(256'hBEEF0000 + 256'(k), k[0] ? 1 : 0);
        end

        // ch0 waits behind a ch1 message and its 20-cycle digest latency
        drv(1, 1'b1, word(1, 0), 1'b0, '0);
        step();
        check("t4_gnt1", gnt, 2'b10);
        drv(0, 1'b1, word(0, 7), 1'b1, 4'b1000);
        send_msg(1, 0, 2, 2, 4'b0111, 1'b0);
        for (int c = 0; c < 20; c++) begin
            check("t4_ch0_blocked", rq0_msg_rdy, 0);
            step();
        end
        cmprss_otpt_res = 256'hCAFE;
        cmprss_otpt_vld = 1'b1;
        step();
        cmprss_otpt_vld = 1'b0;
        check("t4_res_vld1", res_vld1, 1);
        check("t4_res_vld0", res_vld0, 0);
        check("t4_res_d", res_d, 256'hCAFE);
        check("t4_gnt_t1", gnt, 0);
        check("t4_ch0_rdy_t1", rq0_msg_rdy, 0);
        step();
        check("t4_gnt_t2", gnt, 2'b01);
        check("t4_ch0_rdy_t2", rq0_msg_rdy, 1);
        check("t4_ch0_data", msg_inpt_d, word(0, 7));
        step();
        drv(0, 1'b0, '0, 1'b0, '0);
        check("t4_ch0_wait", busy, 1);
        return_res(256'hF00D, 0);

        // Stray digest pulse during XFER sets sticky err, transfer unaffected
        check("t5_err_before", err, 0);
        drv(0, 1'b1, word(0, 0), 1'b0, '0);
        step();
        cmprss_otpt_res = 256'hDEAD;
        cmprss_otpt_vld = 1'b1;
        #1;
        check("t5_hs_word0", {msg_inpt_vld, msg_inpt_rdy, msg_inpt_d}, {2'b11, word(0, 0)});
        step();
        cmprss_otpt_vld = 1'b0;
        check("t5_err_set", err, 1);
        check("t5_no_pulse", {res_vld1, res_vld0}, 0);
        check("t5_res_d_kept", res_d, 256'hF00D);
        check("t5_still_xfer", {busy, gnt}, 3'b101);
        send_msg(0, 1, 3, 3, 4'b1110, 1'b0);
        check("t5_err_sticky", err, 1);
        return_res(256'hAB, 0);
        check("t5_err_after", err, 1);

        // Async reset after word 2 of a 5-word message
        drv(0, 1'b1, word(0, 0), 1'b0, '0);
        step();
        send_msg(0, 0, 2, 5, 4'b1111, 1'b0);
        drv(0, 1'b1, word(0, 2), 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_gnt", gnt, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err, 0);
        check("t6_res_d", res_d, 0);
        check("t6_rdy", {rq1_msg_rdy, rq0_msg_rdy}, 0);
        check("t6_inpt", {msg_inpt_vld, msg_inpt_lst, msg_inpt_d, msg_inpt_vld_byte}, 0);
        drv(0, 1'b0, '0, 1'b0, '0);
        step();
        rst_n = 1'b1;
        step();
        drv(0, 1'b1, word(0, 9), 1'b1, 4'b0001);
        drv(1, 1'b1, word(1, 9), 1'b1, 4'b0001);
        step();
        check("t6_tie_ch0", gnt, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
